// File: rtl/extrator_caminho_if.sv
// Bus bundle for extrator_caminho: the predecessor-memory read port and the
// path output stream. The master side is the path extractor; the slave side
// is the memory plus the path consumer.
interface extrator_caminho_if #(
    parameter int ADDR_WIDTH = 12
) ();
    // Predecessor memory read port (data returns one cycle after the strobe)
    logic                  ant_rd_en_out;
    logic [ADDR_WIDTH-1:0] ant_rd_addr_out;
    logic [ADDR_WIDTH-1:0] ant_rd_data_in;

    // Path output stream, source first, destination flagged as last
    logic                  caminho_valid_out;
    logic                  caminho_ready_in;
    logic [ADDR_WIDTH-1:0] caminho_data_out;
    logic                  caminho_last_out;

    modport master (
        output ant_rd_en_out,
        output ant_rd_addr_out,
        input  ant_rd_data_in,
        output caminho_valid_out,
        input  caminho_ready_in,
        output caminho_data_out,
        output caminho_last_out
    );

    modport slave (
        input  ant_rd_en_out,
        input  ant_rd_addr_out,
        output ant_rd_data_in,
        input  caminho_valid_out,
        output caminho_ready_in,
        input  caminho_data_out,
        input  caminho_last_out
    );
endinterface

// File: rtl/extrator_caminho.sv
// Path extractor: starting at the destination node, follows the predecessor
// memory back to the source, pushing every node on a LIFO, then streams the
// LIFO out so the path appears in source-to-destination order.
module extrator_caminho #(
    parameter int ADDR_WIDTH  = 12,
    parameter int MAX_CAMINHO = 64,
    parameter int CONT_WIDTH  = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  iniciar_in,
    input  logic [ADDR_WIDTH-1:0] fonte_in,
    input  logic [ADDR_WIDTH-1:0] destino_in,
    output logic                  ocupado_out,
    output logic                  pronto_out,
    output logic                  erro_out,
    output logic [CONT_WIDTH-1:0] tamanho_out,
    extrator_caminho_if.master    bus
);

    // LIFO index width; the counter width must be able to hold MAX_CAMINHO
    localparam int IDX_WIDTH = (MAX_CAMINHO > 1) ? $clog2(MAX_CAMINHO) : 1;
    localparam logic [CONT_WIDTH-1:0] CHEIO = CONT_WIDTH'(MAX_CAMINHO);
    localparam logic [CONT_WIDTH-1:0] UM    = CONT_WIDTH'(1);

    // Controller states
    localparam logic [2:0] OCIOSO = 3'd0;  // idle, waiting for a start
    localparam logic [2:0] LER    = 3'd1;  // issue predecessor read of cur
    localparam logic [2:0] ESPERA = 3'd2;  // predecessor data is on the bus
    localparam logic [2:0] EMITIR = 3'd3;  // stream LIFO to the consumer
    localparam logic [2:0] FIM    = 3'd4;  // one-cycle completion pulse

    logic [2:0]            estado_q, estado_d;
    logic [ADDR_WIDTH-1:0] fonte_q, fonte_d;
    logic [ADDR_WIDTH-1:0] cur_q, cur_d;
    logic [CONT_WIDTH-1:0] tamanho_q, tamanho_d;
    logic [CONT_WIDTH-1:0] ptr_q, ptr_d;      // live LIFO occupancy
    logic                  erro_q, erro_d;

    // LIFO storage; contents need no reset because occupancy gates every read
    logic [ADDR_WIDTH-1:0] pilha [MAX_CAMINHO];
    logic                  push_en;
    logic [IDX_WIDTH-1:0]  push_idx;
    logic [ADDR_WIDTH-1:0] push_val;
    logic [IDX_WIDTH-1:0]  topo_idx;
    logic [ADDR_WIDTH-1:0] topo_val;

    logic [ADDR_WIDTH-1:0] ant_dado;
    logic                  emitindo;
    logic                  ultimo;
    logic                  handshake;

    assign ant_dado  = bus.ant_rd_data_in;
    assign emitindo  = (estado_q == EMITIR);
    assign ultimo    = (ptr_q == UM);
    assign handshake = emitindo && bus.caminho_ready_in;
    assign topo_idx  = IDX_WIDTH'(ptr_q - UM);
    assign topo_val  = pilha[topo_idx];

    // Next-state, LIFO push/pop and walk bookkeeping
    always_comb begin
        estado_d  = estado_q;
        fonte_d   = fonte_q;
        cur_d     = cur_q;
        tamanho_d = tamanho_q;
        ptr_d     = ptr_q;
        erro_d    = erro_q;
        push_en   = 1'b0;
        push_idx  = IDX_WIDTH'(ptr_q);
        push_val  = ant_dado;

        case (estado_q)
            OCIOSO: begin
                if (iniciar_in) begin
                    // The destination is stored as the LIFO bottom and as the
                    // walk cursor, so no separate destination register is kept.
                    fonte_d   = fonte_in;
                    cur_d     = destino_in;
                    push_en   = 1'b1;
                    push_idx  = '0;
                    push_val  = destino_in;
                    ptr_d     = UM;
                    tamanho_d = UM;
                    erro_d    = 1'b0;
                    estado_d  = (fonte_in == destino_in) ? EMITIR : LER;
                end
            end

            LER: begin
                estado_d = ESPERA;
            end

            ESPERA: begin
                if (ant_dado == cur_q) begin
                    // Node is its own predecessor: the chain never reaches
                    // the source.
                    erro_d   = 1'b1;
                    ptr_d    = '0;
                    estado_d = FIM;
                end else if (tamanho_q == CHEIO) begin
                    // No room for another node: overflow, drop the path.
                    erro_d   = 1'b1;
                    ptr_d    = '0;
                    estado_d = FIM;
                end else begin
                    push_en   = 1'b1;
                    ptr_d     = ptr_q + UM;
                    tamanho_d = tamanho_q + UM;
                    cur_d     = ant_dado;
                    estado_d  = (ant_dado == fonte_q) ? EMITIR : LER;
                end
            end

            EMITIR: begin
                // Pop on every accepted node; tamanho keeps the pushed count.
                if (handshake) begin
                    ptr_d = ptr_q - UM;
                    if (ultimo) begin
                        estado_d = FIM;
                    end
                end
            end

            FIM: begin
                estado_d = OCIOSO;
            end

            default: begin
                estado_d = OCIOSO;
            end
        endcase
    end

    // Control and status registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q  <= OCIOSO;
            fonte_q   <= '0;
            cur_q     <= '0;
            tamanho_q <= '0;
            ptr_q     <= '0;
            erro_q    <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            fonte_q   <= fonte_d;
            cur_q     <= cur_d;
            tamanho_q <= tamanho_d;
            ptr_q     <= ptr_d;
            erro_q    <= erro_d;
        end
    end

    // LIFO storage write port
    always_ff @(posedge clk) begin
        if (push_en) begin
            pilha[push_idx] <= push_val;
        end
    end

    // Outputs are decoded from registered state, so reset forces them to 0
    assign ocupado_out           = (estado_q != OCIOSO);
    assign pronto_out            = (estado_q == FIM);
    assign erro_out              = erro_q;
    assign tamanho_out           = tamanho_q;

    assign bus.ant_rd_en_out     = (estado_q == LER);
    assign bus.ant_rd_addr_out   = (estado_q == LER) ? cur_q : '0;

    assign bus.caminho_valid_out = emitindo;
    assign bus.caminho_data_out  = emitindo ? topo_val : '0;
    assign bus.caminho_last_out  = emitindo && ultimo;

endmodule

// File: tb/tb_extrator_caminho.sv
// Self-checking bench for extrator_caminho: directed scenarios plus random
// predecessor chains checked against a list-based path model.
`timescale 1ns/1ps
module tb_extrator_caminho;

    localparam int AW   = 12;
    localparam int MAXC = 4;
    localparam int CW   = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          iniciar_in = 1'b0;
    logic [AW-1:0] fonte_in = '0;
    logic [AW-1:0] destino_in = '0;
    logic          ocupado_out;
    logic          pronto_out;
    logic          erro_out;
    logic [CW-1:0] tamanho_out;

    extrator_caminho_if #(.ADDR_WIDTH(AW)) bus ();

    extrator_caminho #(
        .ADDR_WIDTH (AW),
        .MAX_CAMINHO(MAXC),
        .CONT_WIDTH (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .iniciar_in (iniciar_in),
        .fonte_in   (fonte_in),
        .destino_in (destino_in),
        .ocupado_out(ocupado_out),
        .pronto_out (pronto_out),
        .erro_out   (erro_out),
        .tamanho_out(tamanho_out),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    // Predecessor memory: data returns one cycle after the strobe
    logic [AW-1:0] ant_mem [4096];
    always @(posedge clk) begin
        if (bus.ant_rd_en_out) bus.ant_rd_data_in <= ant_mem[bus.ant_rd_addr_out];
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Observations of one operation
    logic [AW-1:0] obs_data[$];
    logic [AW-1:0] obs_reads[$];
    int            obs_last_cnt, obs_last_idx;
    int            obs_first_valid, obs_pronto_cyc, obs_unstable;
    bit            obs_timeout;
    logic          obs_erro, obs_erro_c1, obs_busy_c1, obs_after_pronto, obs_after_busy;
    logic [CW-1:0] obs_tam;

    // Reference model results
    logic [AW-1:0] exp_path[$];
    logic [AW-1:0] exp_reads[$];
    bit            exp_erro;
    int            exp_tam;

    function automatic bit same_q(input logic [AW-1:0] a[$], input logic [AW-1:0] b[$]);
        if (a.size() != b.size()) return 1'b0;
        foreach (a[i]) if (a[i] !== b[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic string q_str(input logic [AW-1:0] q[$]);
        string s = "{";
        foreach (q[i]) s = {s, $sformatf(" %0d", q[i])};
        return {s, " }"};
    endfunction

    // Model: walk predecessors from destination back to source with a list
    task automatic ref_walk(input logic [AW-1:0] f, input logic [AW-1:0] d);
        logic [AW-1:0] rev[$];
        logic [AW-1:0] cur, nxt;
        exp_reads.delete();
        exp_path.delete();
        exp_erro = 1'b0;
        rev.push_back(d);
        cur = d;
        if (f != d) begin
            for (int s = 0; s < 64; s++) begin
                exp_reads.push_back(cur);
                nxt = ant_mem[cur];
                if (nxt == cur || rev.size() == MAXC) begin
                    exp_erro = 1'b1;
                    break;
                end
                rev.push_back(nxt);
                cur = nxt;
                if (nxt == f) break;
            end
        end
        exp_tam = rev.size();
        if (!exp_erro) while (rev.size() > 0) exp_path.push_back(rev.pop_back());
    endtask

    // Run one operation; stall<0 means random ready, else ready low for
    // 'stall' cycles on each node. hold_start keeps iniciar_in high with junk
    // operands while the block is busy.
    task automatic do_op(input logic [AW-1:0] f, input logic [AW-1:0] d,
                         input int stall, input bit hold_start);
        int            wait_cnt = 0;
        bit            prev_stall = 0;
        logic [AW-1:0] prev_data = '0;
        logic          prev_last = 1'b0;
        obs_data.delete();
        obs_reads.delete();
        obs_last_cnt = 0; obs_last_idx = -1;
        obs_first_valid = -1; obs_pronto_cyc = -1; obs_unstable = 0;
        obs_timeout = 0; obs_erro = 1'bx; obs_tam = 'x;
        @(negedge clk);
        fonte_in = f; destino_in = d; iniciar_in = 1'b1;
        bus.caminho_ready_in = (stall == 0);
        @(posedge clk);
        #1;
        if (hold_start) begin
            fonte_in = AW'($urandom); destino_in = AW'($urandom);
        end else begin
            iniciar_in = 1'b0;
        end
        obs_erro_c1 = erro_out;
        obs_busy_c1 = ocupado_out;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (bus.ant_rd_en_out) obs_reads.push_back(bus.ant_rd_addr_out);
            if (bus.caminho_valid_out) begin
                if (obs_first_valid < 0) obs_first_valid = k;
                if (prev_stall && (bus.caminho_data_out !== prev_data ||
                                   bus.caminho_last_out !== prev_last)) obs_unstable++;
                if (stall < 0) begin
                    bus.caminho_ready_in = 1'($urandom_range(0, 1));
                end else if (wait_cnt < stall) begin
                    bus.caminho_ready_in = 1'b0; wait_cnt++;
                end else begin
                    bus.caminho_ready_in = 1'b1; wait_cnt = 0;
                end
                if (bus.caminho_ready_in) begin
                    if (bus.caminho_last_out) begin
                        obs_last_cnt++; obs_last_idx = obs_data.size();
                    end
                    obs_data.push_back(bus.caminho_data_out);
                end
                prev_stall = !bus.caminho_ready_in;
                prev_data  = bus.caminho_data_out;
                prev_last  = bus.caminho_last_out;
            end else begin
                prev_stall = 0;
                bus.caminho_ready_in = (stall == 0);
            end
            if (pronto_out) begin
                obs_pronto_cyc = k; obs_erro = erro_out; obs_tam = tamanho_out;
                iniciar_in = 1'b0;
                break;
            end
        end
        iniciar_in = 1'b0;
        if (obs_pronto_cyc < 0) obs_timeout = 1;
        @(negedge clk);
        obs_after_pronto = pronto_out;
        obs_after_busy   = ocupado_out;
        bus.caminho_ready_in = 1'b0;
    endtask

    task automatic test_reset();
        bus.caminho_ready_in = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({ocupado_out, pronto_out, erro_out, tamanho_out, bus.caminho_valid_out,
             bus.caminho_last_out, bus.caminho_data_out, bus.ant_rd_en_out,
             bus.ant_rd_addr_out} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ocupado=%b pronto=%b erro=%b tam=%0d valid=%b rd_en=%b, expected all 0",
                     ocupado_out, pronto_out, erro_out, tamanho_out, bus.caminho_valid_out, bus.ant_rd_en_out);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ocupado_out !== 1'b0 || tamanho_out !== '0) begin
            n_fail++;
            $display("FAIL reset_release_idle: got ocupado=%b tam=%0d, expected 0 0", ocupado_out, tamanho_out);
        end
        $display("test_reset done");
    endtask

    // fonte=5, destino=9, ant[9]=7, ant[7]=5, ready held high
    task automatic test_chain(input string nm);
        logic [AW-1:0] e_d[$] = '{12'd5, 12'd7, 12'd9};
        logic [AW-1:0] e_r[$] = '{12'd9, 12'd7};
        ant_mem[9] = 12'd7; ant_mem[7] = 12'd5;
        do_op(12'd5, 12'd9, 0, 0);
        n_checks++;
        if (!same_q(obs_reads, e_r)) begin
            n_fail++; $display("FAIL %s_reads: got %s expected %s", nm, q_str(obs_reads), q_str(e_r));
        end
        n_checks++;
        if (!same_q(obs_data, e_d)) begin
            n_fail++; $display("FAIL %s_data: got %s expected %s", nm, q_str(obs_data), q_str(e_d));
        end
        n_checks++;
        if (obs_last_cnt != 1 || obs_last_idx != 2) begin
            n_fail++; $display("FAIL %s_last: got count %0d at %0d expected 1 at 2", nm, obs_last_cnt, obs_last_idx);
        end
        n_checks++;
        if (obs_tam !== 3'd3 || obs_erro !== 1'b0) begin
            n_fail++; $display("FAIL %s_status: got tam=%0d erro=%b expected 3 0", nm, obs_tam, obs_erro);
        end
        n_checks++;
        if (obs_first_valid != 5) begin
            n_fail++; $display("FAIL %s_latency: got first valid at %0d expected 5", nm, obs_first_valid);
        end
        n_checks++;
        if (obs_pronto_cyc != 8 || obs_after_pronto !== 1'b0 || obs_after_busy !== 1'b0) begin
            n_fail++; $display("FAIL %s_pronto: got cycle %0d after=%b busy=%b expected 8 0 0",
                               nm, obs_pronto_cyc, obs_after_pronto, obs_after_busy);
        end
        $display("test_chain %s: path %s", nm, q_str(obs_data));
    endtask

    task automatic test_same_node();
        do_op(12'd3, 12'd3, 0, 0);
        n_checks++;
        if (obs_reads.size() != 0 || obs_busy_c1 !== 1'b1) begin
            n_fail++; $display("FAIL same_node_reads: got %0d reads busy=%b expected 0 reads busy=1", obs_reads.size(), obs_busy_c1);
        end
        n_checks++;
        if (obs_data.size() != 1 || obs_data[0] !== 12'd3 || obs_last_idx != 0 || obs_first_valid != 1) begin
            n_fail++; $display("FAIL same_node_emit: got %s last@%0d first@%0d expected { 3 } last@0 first@1",
                               q_str(obs_data), obs_last_idx, obs_first_valid);
        end
        n_checks++;
        if (obs_tam !== 3'd1 || obs_pronto_cyc != 2 || obs_erro !== 1'b0) begin
            n_fail++; $display("FAIL same_node_end: got tam=%0d pronto@%0d erro=%b expected 1 2 0", obs_tam, obs_pronto_cyc, obs_erro);
        end
        $display("test_same_node done: path %s", q_str(obs_data));
    endtask

    task automatic test_backpressure();
        logic [AW-1:0] e_d[$] = '{12'd5, 12'd7, 12'd9};
        ant_mem[9] = 12'd7; ant_mem[7] = 12'd5;
        do_op(12'd5, 12'd9, 4, 0);
        n_checks++;
        if (!same_q(obs_data, e_d) || obs_last_idx != 2 || obs_last_cnt != 1) begin
            n_fail++; $display("FAIL backpressure_data: got %s last@%0d expected %s last@2", q_str(obs_data), obs_last_idx, q_str(e_d));
        end
        n_checks++;
        if (obs_unstable != 0) begin
            n_fail++; $display("FAIL backpressure_stable: got %0d changes while stalled expected 0", obs_unstable);
        end
        n_checks++;
        if (obs_first_valid != 5 || obs_pronto_cyc != 20 || obs_tam !== 3'd3) begin
            n_fail++; $display("FAIL backpressure_timing: got first@%0d pronto@%0d tam=%0d expected 5 20 3",
                               obs_first_valid, obs_pronto_cyc, obs_tam);
        end
        $display("test_backpressure done: path %s", q_str(obs_data));
    endtask

    task automatic test_self_loop();
        ant_mem[9] = 12'd9;
        do_op(12'd5, 12'd9, 0, 0);
        n_checks++;
        if (obs_erro !== 1'b1 || obs_pronto_cyc != 3 || obs_tam !== 3'd1) begin
            n_fail++; $display("FAIL self_loop_end: got erro=%b pronto@%0d tam=%0d expected 1 3 1", obs_erro, obs_pronto_cyc, obs_tam);
        end
        n_checks++;
        if (obs_first_valid != -1 || obs_reads.size() != 1) begin
            n_fail++; $display("FAIL self_loop_emit: got first valid %0d reads %s expected -1 { 9 }", obs_first_valid, q_str(obs_reads));
        end
        n_checks++;
        if (erro_out !== 1'b1) begin
            n_fail++; $display("FAIL self_loop_sticky: got erro=%b expected 1", erro_out);
        end
        // The next accepted start clears the error flag in its first cycle
        do_op(12'd3, 12'd3, 0, 0);
        n_checks++;
        if (obs_erro_c1 !== 1'b0 || obs_erro !== 1'b0) begin
            n_fail++; $display("FAIL error_clear: got erro=%b/%b expected 0/0", obs_erro_c1, obs_erro);
        end
        ant_mem[9] = 12'd7;
        $display("test_self_loop done");
    endtask

    // Six-node chain 100..105 through a 4-deep LIFO
    task automatic test_overflow();
        logic [AW-1:0] e_r[$] = '{12'd105, 12'd104, 12'd103, 12'd102};
        for (int i = 101; i <= 105; i++) ant_mem[i] = AW'(i - 1);
        do_op(12'd100, 12'd105, 0, 0);
        n_checks++;
        if (obs_erro !== 1'b1 || obs_tam !== 3'd4 || obs_pronto_cyc != 9) begin
            n_fail++; $display("FAIL overflow_end: got erro=%b tam=%0d pronto@%0d expected 1 4 9", obs_erro, obs_tam, obs_pronto_cyc);
        end
        n_checks++;
        if (obs_first_valid != -1 || !same_q(obs_reads, e_r)) begin
            n_fail++; $display("FAIL overflow_walk: got first %0d reads %s expected -1 %s", obs_first_valid, q_str(obs_reads), q_str(e_r));
        end
        $display("test_overflow done");
    endtask

    task automatic test_reset_mid();
        int pronto_seen = 0;
        ant_mem[9] = 12'd7; ant_mem[7] = 12'd5;
        @(negedge clk);
        fonte_in = 12'd5; destino_in = 12'd9; iniciar_in = 1'b1; bus.caminho_ready_in = 1'b1;
        @(posedge clk);
        #1 iniciar_in = 1'b0;
        repeat (6) @(negedge clk);
        n_checks++;
        if (bus.caminho_valid_out !== 1'b1 || bus.caminho_data_out !== 12'd7) begin
            n_fail++; $display("FAIL reset_mid_position: got valid=%b data=%0d expected 1 7", bus.caminho_valid_out, bus.caminho_data_out);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({ocupado_out, pronto_out, erro_out, tamanho_out, bus.caminho_valid_out,
             bus.caminho_last_out, bus.caminho_data_out, bus.ant_rd_en_out} !== '0) begin
            n_fail++; $display("FAIL reset_mid_outputs: got ocupado=%b valid=%b data=%0d tam=%0d expected all 0",
                               ocupado_out, bus.caminho_valid_out, bus.caminho_data_out, tamanho_out);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (pronto_out) pronto_seen++;
        end
        rst_n = 1'b1;
        @(negedge clk);
        if (pronto_out) pronto_seen++;
        n_checks++;
        if (pronto_seen != 0) begin
            n_fail++; $display("FAIL reset_mid_pronto: got %0d pronto cycles expected 0", pronto_seen);
        end
        $display("test_reset_mid done");
        test_chain("after_reset");
    endtask

    task automatic test_ignore_start();
        logic [AW-1:0] e_d[$] = '{12'd5, 12'd7, 12'd9};
        ant_mem[9] = 12'd7; ant_mem[7] = 12'd5;
        do_op(12'd5, 12'd9, 0, 1);
        n_checks++;
        if (!same_q(obs_data, e_d) || obs_reads.size() != 2 || obs_pronto_cyc != 8) begin
            n_fail++; $display("FAIL ignore_start: got %s reads=%0d pronto@%0d expected %s 2 8",
                               q_str(obs_data), obs_reads.size(), obs_pronto_cyc, q_str(e_d));
        end
        $display("test_ignore_start done");
    endtask

    task automatic test_random();
        logic [AW-1:0] nodes[$];
        logic [AW-1:0] a, f, d;
        int            len, stall, exp_fv, exp_pc;
        bit            dup;
        for (int t = 0; t < 40; t++) begin
            len = $urandom_range(1, 6);
            nodes.delete();
            while (nodes.size() < len) begin
                a = AW'($urandom_range(0, 4095));
                dup = 0;
                foreach (nodes[i]) if (nodes[i] == a) dup = 1;
                if (!dup) nodes.push_back(a);
            end
            for (int i = 1; i < len; i++) ant_mem[nodes[i]] = nodes[i-1];
            if (len > 1 && $urandom_range(0, 4) == 0) begin
                a = nodes[$urandom_range(1, len - 1)];
                ant_mem[a] = a;
            end
            f = nodes[0];
            d = nodes[len-1];
            stall = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 2));
            ref_walk(f, d);
            do_op(f, d, stall, 0);
            exp_fv = exp_erro ? -1 : 2 * (exp_tam - 1) + 1;
            exp_pc = exp_erro ? 2 * exp_reads.size() + 1 : 2 * exp_reads.size() + exp_tam + 1;
            n_checks++;
            if (obs_timeout) begin
                n_fail++; $display("FAIL rand%0d_timeout: got no pronto expected pronto", t);
            end
            n_checks++;
            if (!same_q(obs_reads, exp_reads)) begin
                n_fail++; $display("FAIL rand%0d_reads: got %s expected %s", t, q_str(obs_reads), q_str(exp_reads));
            end
            n_checks++;
            if (!same_q(obs_data, exp_path)) begin
                n_fail++; $display("FAIL rand%0d_data: got %s expected %s", t, q_str(obs_data), q_str(exp_path));
            end
            n_checks++;
            if (obs_last_cnt != (exp_erro ? 0 : 1) || obs_last_idx != exp_path.size() - 1) begin
                n_fail++; $display("FAIL rand%0d_last: got count %0d at %0d expected at %0d", t, obs_last_cnt, obs_last_idx, exp_path.size() - 1);
            end
            n_checks++;
            if (obs_erro !== exp_erro || int'(obs_tam) != exp_tam) begin
                n_fail++; $display("FAIL rand%0d_status: got erro=%b tam=%0d expected %0d %0d", t, obs_erro, obs_tam, exp_erro, exp_tam);
            end
            n_checks++;
            if (obs_first_valid != exp_fv || obs_unstable != 0) begin
                n_fail++; $display("FAIL rand%0d_valid: got first@%0d unstable=%0d expected %0d 0", t, obs_first_valid, obs_unstable, exp_fv);
            end
            if (exp_erro || stall == 0) begin
                n_checks++;
                if (obs_pronto_cyc != exp_pc) begin
                    n_fail++; $display("FAIL rand%0d_pronto: got cycle %0d expected %0d", t, obs_pronto_cyc, exp_pc);
                end
            end
            $display("rand%0d: len=%0d stall=%0d erro=%0d tam=%0d path %s", t, len, stall, exp_erro, exp_tam, q_str(obs_data));
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ant_mem[i] = '0;
        test_reset();
        test_chain("chain");
        test_same_node();
        test_backpressure();
        test_self_loop();
        test_overflow();
        test_reset_mid();
        test_ignore_start();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog expired");
    end

endmodule
